igr_wadj_seg_merge: RTL and testbench

Ingress width adjuster for the packet switch. It packs narrow segmented AXI-Stream beats (default 128 bits) into wide beats (default 512 bits). Every packet starts at lane 0 of a wide beat. It sits between a narrow port-side datapath and the wide switch core, and is the inverse of the egress segment splitter.

---
 rtl/igr_wadj_seg_merge.sv | 175 +++++++++++++++++
 tb/tb_igr_wadj_seg_merge.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/igr_wadj_seg_merge.sv
// Ingress width adjuster: packs narrow segmented stream beats into wide beats,
// with every packet starting at lane 0 of a wide beat.

package packet_switch_pkg;
    localparam int unsigned PORT_W     = 4;
    localparam int unsigned BYTESVLD_W = 7;

    typedef struct packed {
        logic                  sop;
        logic                  eop;
        logic                  sos;
        logic                  eos;
        logic                  hdr_segment;
        logic                  payld_segment;
        logic [PORT_W-1:0]     igr_port;
        logic [PORT_W-1:0]     egr_port;
        logic [BYTESVLD_W-1:0] bytesvld;
    } SEGMENT_INFO_S;
endpackage

module igr_wadj_seg_merge #(
    parameter int unsigned IGR_TDATA_WIDTH    = 128,
    parameter int unsigned IGR_NUM_SEG        = 2,
    parameter int unsigned IGR_SEG_WIDTH      = IGR_TDATA_WIDTH / IGR_NUM_SEG,
    parameter int unsigned EGR_TDATA_WIDTH    = 512,
    parameter int unsigned EGR_NUM_SEG        = EGR_TDATA_WIDTH / IGR_SEG_WIDTH,
    parameter int unsigned USERMETADATA_WIDTH = 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   igr_tvalid,
    input  logic [IGR_TDATA_WIDTH-1:0]             igr_tdata,
    input  logic [IGR_TDATA_WIDTH/8-1:0]           igr_tkeep,
    input  logic                                   igr_tlast,
    input  logic [USERMETADATA_WIDTH-1:0]          igr_tuser_usermetadata,
    input  packet_switch_pkg::SEGMENT_INFO_S       igr_tuser_segment_info,
    output logic                                   igr_tready,
    output logic                                   egr_tvalid,
    output logic [EGR_NUM_SEG*IGR_SEG_WIDTH-1:0]   egr_tdata,
    output logic [EGR_TDATA_WIDTH/8-1:0]           egr_tkeep,
    output logic                                   egr_tlast,
    output logic [EGR_NUM_SEG-1:0]                 egr_tlast_segment,
    output logic [USERMETADATA_WIDTH-1:0]          egr_tuser_usermetadata,
    output packet_switch_pkg::SEGMENT_INFO_S       egr_tuser_segment_info,
    input  logic                                   egr_tready,
    output logic                                   err_missing_eop
);
    import packet_switch_pkg::*;

    localparam int unsigned RATIO      = EGR_TDATA_WIDTH / IGR_TDATA_WIDTH;
    localparam int unsigned CNT_W      = $clog2(RATIO);
    localparam int unsigned IGR_KEEP_W = IGR_TDATA_WIDTH / 8;
    localparam int unsigned EGR_KEEP_W = EGR_TDATA_WIDTH / 8;
    localparam int unsigned SEG_BYTES  = IGR_SEG_WIDTH / 8;
    localparam int unsigned OUT_W      = EGR_NUM_SEG * IGR_SEG_WIDTH;
    localparam int unsigned POP_W      = $clog2(EGR_KEEP_W + 1);
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

    logic [EGR_TDATA_WIDTH-1:0]    acc_data;
    logic [EGR_KEEP_W-1:0]         acc_keep;
    logic [USERMETADATA_WIDTH-1:0] acc_meta;
    SEGMENT_INFO_S                 acc_info;
    logic [CNT_W-1:0]              cnt;

    logic out_free, flush_cond, complete_cond, xfer;
    logic do_append, do_complete, do_flush, do_load;
    logic [EGR_TDATA_WIDTH-1:0]    load_data;
    logic [EGR_KEEP_W-1:0]         load_keep;
    logic                          load_last;
    logic [USERMETADATA_WIDTH-1:0] lane0_meta;
    SEGMENT_INFO_S                 lane0_info;
    SEGMENT_INFO_S                 load_info;
    logic [POP_W-1:0]              load_pop;
    logic [EGR_NUM_SEG-1:0]        load_lseg;

    // Handshake classification
    assign out_free      = !egr_tvalid || egr_tready;
    assign flush_cond    = igr_tvalid && igr_tuser_segment_info.sop && (cnt != '0);
    assign complete_cond = igr_tvalid && (igr_tlast || (cnt == LAST_LANE));
    assign igr_tready    = rst_n && !flush_cond && (!complete_cond || out_free);
    assign xfer          = igr_tvalid && igr_tready;
    assign do_append     = xfer && !igr_tlast && (cnt != LAST_LANE);
    assign do_complete   = xfer && (igr_tlast || (cnt == LAST_LANE));
    assign do_flush      = flush_cond && out_free;
    assign do_load       = do_complete || do_flush;

    // Accumulator with the current beat dropped into lane cnt (not on a flush)
    always_comb begin
        load_data  = acc_data;
        load_keep  = acc_keep;
        load_last  = !flush_cond && igr_tlast;
        lane0_meta = (cnt == '0) ? igr_tuser_usermetadata : acc_meta;
        lane0_info = (cnt == '0) ? igr_tuser_segment_info : acc_info;
        if (!flush_cond) begin
            for (int l = 0; l < int'(RATIO); l++) begin
                if (cnt == CNT_W'(l)) begin
                    load_data[l*IGR_TDATA_WIDTH +: IGR_TDATA_WIDTH] = igr_tdata;
                    load_keep[l*IGR_KEEP_W +: IGR_KEEP_W]           = igr_tkeep;
                end
            end
        end
    end

    // Byte count and one-hot marker of the highest populated segment
    always_comb begin
        load_pop  = '0;
        load_lseg = '0;
        for (int i = 0; i < int'(EGR_KEEP_W); i++) begin
            load_pop = load_pop + POP_W'(load_keep[i]);
        end
        for (int s = 0; s < int'(EGR_NUM_SEG); s++) begin
            if (|load_keep[s*SEG_BYTES +: SEG_BYTES]) begin
                load_lseg    = '0;
                load_lseg[s] = 1'b1;
            end
        end
        if (!load_last) begin
            load_lseg = '0;
        end
        load_info          = lane0_info;
        load_info.eop      = load_last;
        load_info.eos      = load_last;
        load_info.bytesvld = BYTESVLD_W'(load_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_data <= '0;
            acc_keep <= '0;
            acc_meta <= '0;
            acc_info <= '0;
            cnt      <= '0;
        end else if (do_load) begin
            acc_data <= '0;
            acc_keep <= '0;
            acc_meta <= '0;
            acc_info <= '0;
            cnt      <= '0;
        end else if (do_append) begin
            acc_data <= load_data;
            acc_keep <= load_keep;
            acc_meta <= lane0_meta;
            acc_info <= lane0_info;
            cnt      <= cnt + CNT_W'(1);
        end
    end

    // Output stage: load on complete/flush, hold while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            egr_tvalid             <= 1'b0;
            egr_tdata              <= '0;
            egr_tkeep              <= '0;
            egr_tlast              <= 1'b0;
            egr_tlast_segment      <= '0;
            egr_tuser_usermetadata <= '0;
            egr_tuser_segment_info <= '0;
            err_missing_eop        <= 1'b0;
        end else begin
            err_missing_eop <= do_flush;
            if (do_load) begin
                egr_tvalid             <= 1'b1;
                egr_tdata              <= OUT_W'(load_data);
                egr_tkeep              <= load_keep;
                egr_tlast              <= load_last;
                egr_tlast_segment      <= load_lseg;
                egr_tuser_usermetadata <= lane0_meta;
                egr_tuser_segment_info <= load_info;
            end else if (egr_tready) begin
                egr_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_igr_wadj_seg_merge.sv
// Directed bench for igr_wadj_seg_merge: packing, partial packets, backpressure,
// missing-EOP flush and mid-packet reset.

module tb_igr_wadj_seg_merge;
    import packet_switch_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          igr_tvalid = 1'b0;
    logic [127:0]  igr_tdata = '0;
    logic [15:0]   igr_tkeep = '0;
    logic          igr_tlast = 1'b0;
    logic [0:0]    igr_tuser_usermetadata = '0;
    SEGMENT_INFO_S igr_tuser_segment_info = '0;
    logic          igr_tready;
    logic          egr_tvalid;
    logic [511:0]  egr_tdata;
    logic [63:0]   egr_tkeep;
    logic          egr_tlast;
    logic [7:0]    egr_tlast_segment;
    logic [0:0]    egr_tuser_usermetadata;
    SEGMENT_INFO_S egr_tuser_segment_info;
    logic          egr_tready = 1'b0;
    logic          err_missing_eop;

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;

    typedef struct {
        logic [511:0]  data;
        logic [63:0]   keep;
        logic          last;
        logic [7:0]    lseg;
        logic [0:0]    meta;
        SEGMENT_INFO_S info;
    } word_t;

    word_t q[$];

    always #5 clk = ~clk;

    igr_wadj_seg_merge dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .igr_tvalid             (igr_tvalid),
        .igr_tdata              (igr_tdata),
        .igr_tkeep              (igr_tkeep),
        .igr_tlast              (igr_tlast),
        .igr_tuser_usermetadata (igr_tuser_usermetadata),
        .igr_tuser_segment_info (igr_tuser_segment_info),
        .igr_tready             (igr_tready),
        .egr_tvalid             (egr_tvalid),
        .egr_tdata              (egr_tdata),
        .egr_tkeep              (egr_tkeep),
        .egr_tlast              (egr_tlast),
        .egr_tlast_segment      (egr_tlast_segment),
        .egr_tuser_usermetadata (egr_tuser_usermetadata),
        .egr_tuser_segment_info (egr_tuser_segment_info),
        .egr_tready             (egr_tready),
        .err_missing_eop        (err_missing_eop)
    );

    // Record every egress handshake and every error pulse
    always @(posedge clk) begin
        if (egr_tvalid && egr_tready)
            q.push_back(word_t'{egr_tdata, egr_tkeep, egr_tlast, egr_tlast_segment,
                                egr_tuser_usermetadata, egr_tuser_segment_info});
        if (err_missing_eop) err_pulses++;
    end

    function automatic logic [127:0] bd(input logic [7:0] p, input logic [7:0] b);
        return {8{p, b}};
    endfunction

    function automatic SEGMENT_INFO_S mk_info(input logic sop, input logic [3:0] port);
        SEGMENT_INFO_S s;
        s = '0;
        s.sop         = sop;
        s.sos         = sop;
        s.hdr_segment = sop;
        s.igr_port    = port;
        s.egr_port    = ~port;
        s.bytesvld    = 7'd16;
        return s;
    endfunction

    // Present one beat at a negedge and hold it until accepted
    task automatic send(input logic [127:0] d, input logic [15:0] k, input logic last,
                        input logic sop, input logic [3:0] port, input logic meta);
        logic acc;
        acc = 1'b0;
        igr_tvalid = 1'b1;
        igr_tdata = d;
        igr_tkeep = k;
        igr_tlast = last;
        igr_tuser_segment_info = mk_info(sop, port);
        igr_tuser_usermetadata = meta;
        for (int i = 0; i < 100 && !acc; i++) begin
            #4;
            acc = igr_tready;
            @(posedge clk);
            @(negedge clk);
        end
        igr_tvalid = 1'b0;
        checks++;
        if (acc !== 1'b1) begin
            errors++;
            $display("FAIL send_accept: beat %h never accepted (got %b, need 1)", d, acc);
        end
    endtask

    task automatic wait_words(input int n);
        for (int i = 0; i < 50 && q.size() < n; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != n) begin
            errors++;
            $display("FAIL word_count: got %0d words, need %0d", q.size(), n);
        end
    endtask

    task automatic test_reset();
        igr_tvalid = 1'b1;
        igr_tlast = 1'b1;
        igr_tuser_segment_info = mk_info(1'b1, 4'd1);
        egr_tready = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (igr_tready !== 1'b0) begin errors++; $display("FAIL reset_igr_tready: got %b need 0", igr_tready); end
        checks++;
        if (egr_tvalid !== 1'b0) begin errors++; $display("FAIL reset_egr_tvalid: got %b need 0", egr_tvalid); end
        checks++;
        if (egr_tkeep !== 64'h0) begin errors++; $display("FAIL reset_egr_tkeep: got %h need 0", egr_tkeep); end
        checks++;
        if (egr_tlast_segment !== 8'h0 || err_missing_eop !== 1'b0) begin
            errors++; $display("FAIL reset_misc: lseg %h err %b need 0/0", egr_tlast_segment, err_missing_eop);
        end
        igr_tvalid = 1'b0;
        igr_tlast = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_64b();
        word_t w;
        q.delete();
        egr_tready = 1'b1;
        send(bd(8'hA1, 8'd0), 16'hFFFF, 1'b0, 1'b1, 4'd3, 1'b1);
        send(bd(8'hA1, 8'd1), 16'hFFFF, 1'b0, 1'b0, 4'd9, 1'b0);
        send(bd(8'hA1, 8'd2), 16'hFFFF, 1'b0, 1'b0, 4'd9, 1'b0);
        send(bd(8'hA1, 8'd3), 16'hFFFF, 1'b1, 1'b0, 4'd9, 1'b0);
        checks++;
        if (egr_tvalid !== 1'b1) begin errors++; $display("FAIL p64_latency: egr_tvalid %b need 1", egr_tvalid); end
        wait_words(1);
        if (q.size() >= 1) begin
            w = q[0];
            checks++;
            if (w.data !== {bd(8'hA1, 8'd3), bd(8'hA1, 8'd2), bd(8'hA1, 8'd1), bd(8'hA1, 8'd0)}) begin
                errors++; $display("FAIL p64_data: got %h", w.data);
            end
            checks++;
            if (w.keep !== {64{1'b1}} || w.last !== 1'b1 || w.lseg !== 8'h80) begin
                errors++; $display("FAIL p64_keep_last: keep %h last %b lseg %h need all-ones/1/80", w.keep, w.last, w.lseg);
            end
            checks++;
            if (w.info.sop !== 1'b1 || w.info.eop !== 1'b1 || w.info.bytesvld !== 7'd64) begin
                errors++; $display("FAIL p64_info: sop %b eop %b bytesvld %0d need 1/1/64", w.info.sop, w.info.eop, w.info.bytesvld);
            end
            checks++;
            if (w.info.igr_port !== 4'd3 || w.info.egr_port !== 4'd12 || w.meta !== 1'b1) begin
                errors++; $display("FAIL p64_lane0: igr_port %0d egr_port %0d meta %b need 3/12/1", w.info.igr_port, w.info.egr_port, w.meta);
            end
        end
    endtask

    task automatic test_20b();
        word_t w;
        q.delete();
        egr_tready = 1'b1;
        send(bd(8'hB2, 8'd0), 16'hFFFF, 1'b0, 1'b1, 4'd2, 1'b0);
        send(bd(8'hB2, 8'd1), 16'h000F, 1'b1, 1'b0, 4'd5, 1'b1);
        wait_words(1);
        if (q.size() >= 1) begin
            w = q[0];
            checks++;
            if (w.keep !== 64'h0000_0000_000F_FFFF || w.lseg !== 8'h04 || w.info.bytesvld !== 7'd20) begin
                errors++; $display("FAIL p20_keep: keep %h lseg %h bytesvld %0d need 000FFFFF/04/20", w.keep, w.lseg, w.info.bytesvld);
            end
            checks++;
            if (w.data[511:256] !== 256'h0 || w.data[255:0] !== {bd(8'hB2, 8'd1), bd(8'hB2, 8'd0)}) begin
                errors++; $display("FAIL p20_data: got %h", w.data);
            end
            checks++;
            if (w.last !== 1'b1 || w.info.sop !== 1'b1 || w.meta !== 1'b0) begin
                errors++; $display("FAIL p20_flags: last %b sop %b meta %b need 1/1/0", w.last, w.info.sop, w.meta);
            end
        end
    endtask

    task automatic test_100b();
        word_t w;
        q.delete();
        egr_tready = 1'b1;
        for (int b = 0; b < 6; b++)
            send(bd(8'hC3, 8'(b)), 16'hFFFF, 1'b0, (b == 0), 4'(b + 1), 1'b0);
        send(bd(8'hC3, 8'd6), 16'h000F, 1'b1, 1'b0, 4'd7, 1'b0);
        wait_words(2);
        if (q.size() >= 2) begin
            w = q[0];
            checks++;
            if (w.keep !== {64{1'b1}} || w.last !== 1'b0 || w.lseg !== 8'h00 || w.info.sop !== 1'b1
                || w.info.eop !== 1'b0 || w.info.bytesvld !== 7'd64) begin
                errors++; $display("FAIL p100_w1: keep %h last %b lseg %h sop %b eop %b bv %0d need ones/0/00/1/0/64",
                                   w.keep, w.last, w.lseg, w.info.sop, w.info.eop, w.info.bytesvld);
            end
            w = q[1];
            checks++;
            if (w.keep !== 64'h0000_000F_FFFF_FFFF || w.lseg !== 8'h10 || w.info.sop !== 1'b0
                || w.info.bytesvld !== 7'd36 || w.last !== 1'b1 || w.info.eop !== 1'b1) begin
                errors++; $display("FAIL p100_w2: keep %h lseg %h sop %b bv %0d last %b eop %b need 0000000FFFFFFFFF/10/0/36/1/1",
                                   w.keep, w.lseg, w.info.sop, w.info.bytesvld, w.last, w.info.eop);
            end
            checks++;
            if (w.data !== {128'h0, bd(8'hC3, 8'd6), bd(8'hC3, 8'd5), bd(8'hC3, 8'd4)} || w.info.igr_port !== 4'd5) begin
                errors++; $display("FAIL p100_w2_data: port %0d data %h", w.info.igr_port, w.data);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [511:0] exp_a, exp_b;
        int bad;
        q.delete();
        exp_a = {bd(8'hD4, 8'd3), bd(8'hD4, 8'd2), bd(8'hD4, 8'd1), bd(8'hD4, 8'd0)};
        exp_b = {bd(8'hE5, 8'd3), bd(8'hE5, 8'd2), bd(8'hE5, 8'd1), bd(8'hE5, 8'd0)};
        egr_tready = 1'b0;
        for (int b = 0; b < 4; b++) send(bd(8'hD4, 8'(b)), 16'hFFFF, (b == 3), (b == 0), 4'd1, 1'b0);
        for (int b = 0; b < 3; b++) send(bd(8'hE5, 8'(b)), 16'hFFFF, 1'b0, (b == 0), 4'd2, 1'b0);
        igr_tvalid = 1'b1;
        igr_tdata = bd(8'hE5, 8'd3);
        igr_tkeep = 16'hFFFF;
        igr_tlast = 1'b1;
        igr_tuser_segment_info = mk_info(1'b0, 4'd2);
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            #4;
            checks++;
            if (igr_tready !== 1'b0) begin
                errors++; $display("FAIL b2b_stall_ready: cycle %0d igr_tready %b need 0", c, igr_tready);
            end
            checks++;
            if (egr_tvalid !== 1'b1 || egr_tdata !== exp_a || egr_tlast !== 1'b1) begin
                errors++; $display("FAIL b2b_hold: cycle %0d valid %b last %b data %h", c, egr_tvalid, egr_tlast, egr_tdata);
            end
            @(posedge clk);
            @(negedge clk);
        end
        egr_tready = 1'b1;
        send(bd(8'hE5, 8'd3), 16'hFFFF, 1'b1, 1'b0, 4'd2, 1'b0);
        wait_words(2);
        if (q.size() >= 2) begin
            checks++;
            if (q[0].data !== exp_a || q[1].data !== exp_b || q[0].last !== 1'b1 || q[1].last !== 1'b1) begin
                errors++; $display("FAIL b2b_order: w0 %h w1 %h", q[0].data, q[1].data);
            end
        end
    endtask

    task automatic test_flush();
        int base;
        word_t w;
        q.delete();
        base = err_pulses;
        egr_tready = 1'b1;
        send(bd(8'hF6, 8'd0), 16'hFFFF, 1'b0, 1'b1, 4'd4, 1'b1);
        send(bd(8'hF6, 8'd1), 16'hFFFF, 1'b0, 1'b0, 4'd4, 1'b0);
        igr_tvalid = 1'b1;
        igr_tdata = bd(8'h17, 8'd0);
        igr_tkeep = 16'hFFFF;
        igr_tlast = 1'b0;
        igr_tuser_segment_info = mk_info(1'b1, 4'd6);
        #4;
        checks++;
        if (igr_tready !== 1'b0) begin errors++; $display("FAIL flush_stall: igr_tready %b need 0", igr_tready); end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (err_missing_eop !== 1'b1) begin errors++; $display("FAIL flush_err: err_missing_eop %b need 1", err_missing_eop); end
        checks++;
        if (egr_tvalid !== 1'b1 || egr_tkeep !== 64'h0000_0000_FFFF_FFFF || egr_tlast !== 1'b0
            || egr_tdata[255:0] !== {bd(8'hF6, 8'd1), bd(8'hF6, 8'd0)}) begin
            errors++; $display("FAIL flush_word: valid %b keep %h last %b", egr_tvalid, egr_tkeep, egr_tlast);
        end
        checks++;
        if (igr_tready !== 1'b1) begin errors++; $display("FAIL flush_resume: igr_tready %b need 1", igr_tready); end
        send(bd(8'h17, 8'd0), 16'hFFFF, 1'b0, 1'b1, 4'd6, 1'b0);
        checks++;
        if (err_missing_eop !== 1'b0) begin errors++; $display("FAIL flush_pulse_len: err_missing_eop %b need 0", err_missing_eop); end
        for (int b = 1; b < 4; b++) send(bd(8'h17, 8'(b)), 16'hFFFF, (b == 3), 1'b0, 4'd6, 1'b0);
        wait_words(2);
        if (q.size() >= 2) begin
            w = q[0];
            checks++;
            if (w.info.sop !== 1'b1 || w.info.eop !== 1'b0 || w.info.bytesvld !== 7'd32 || w.lseg !== 8'h00 || w.meta !== 1'b1) begin
                errors++; $display("FAIL flush_info: sop %b eop %b bv %0d lseg %h meta %b need 1/0/32/00/1",
                                   w.info.sop, w.info.eop, w.info.bytesvld, w.lseg, w.meta);
            end
            w = q[1];
            checks++;
            if (w.data !== {bd(8'h17, 8'd3), bd(8'h17, 8'd2), bd(8'h17, 8'd1), bd(8'h17, 8'd0)}
                || w.keep !== {64{1'b1}} || w.last !== 1'b1 || w.info.igr_port !== 4'd6) begin
                errors++; $display("FAIL flush_next_pkt: keep %h last %b port %0d data %h", w.keep, w.last, w.info.igr_port, w.data);
            end
        end
        checks++;
        if (err_pulses - base != 1) begin errors++; $display("FAIL flush_pulse_count: got %0d need 1", err_pulses - base); end
    endtask

    task automatic test_reset_mid();
        q.delete();
        egr_tready = 1'b1;
        send(bd(8'h28, 8'd0), 16'hFFFF, 1'b0, 1'b1, 4'd8, 1'b0);
        send(bd(8'h28, 8'd1), 16'hFFFF, 1'b0, 1'b0, 4'd8, 1'b0);
        igr_tvalid = 1'b1;
        igr_tdata = bd(8'h28, 8'd2);
        igr_tuser_segment_info = mk_info(1'b0, 4'd8);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (igr_tready !== 1'b0 || egr_tvalid !== 1'b0) begin
            errors++; $display("FAIL rstmid_ctrl: igr_tready %b egr_tvalid %b need 0/0", igr_tready, egr_tvalid);
        end
        checks++;
        if (egr_tkeep !== 64'h0 || egr_tdata !== 512'h0 || egr_tuser_segment_info !== '0) begin
            errors++; $display("FAIL rstmid_clear: keep %h info %h need 0", egr_tkeep, egr_tuser_segment_info);
        end
        @(negedge clk);
        igr_tvalid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        for (int b = 0; b < 4; b++) send(bd(8'h39, 8'(b)), 16'hFFFF, (b == 3), (b == 0), 4'd9, 1'b0);
        wait_words(1);
        if (q.size() >= 1) begin
            checks++;
            if (q[0].keep !== {64{1'b1}} || q[0].last !== 1'b1
                || q[0].data !== {bd(8'h39, 8'd3), bd(8'h39, 8'd2), bd(8'h39, 8'd1), bd(8'h39, 8'd0)}) begin
                errors++; $display("FAIL rstmid_pkt: keep %h last %b data %h", q[0].keep, q[0].last, q[0].data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_64b();
        test_20b();
        test_100b();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
